// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and helpers for the round datapath.
//   AES_STATE_W / AES_BYTE_W : state and byte widths
//   GF_POLY                  : low byte of the GF(2^8) reduction polynomial 0x11B
//   xtime()                  : multiply a byte by x (i.e. by 2) in GF(2^8)
//   byte_lsb()               : (row,col) -> LSB bit offset of byte[r][c] in a 128-bit state
//                              (byte[r][c] lives at bits [127-8r-32c -: 8], column-major)
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam logic [7:0] GF_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic int byte_lsb(input int row, input int col);
    return AES_STATE_W - AES_BYTE_W - AES_BYTE_W * row - 4 * AES_BYTE_W * col;
  endfunction
endpackage

// File: rtl/aes_mixcol_column.sv
// aes_mixcol_column: combinational MixColumns on one 32-bit state column.
//   col_in  : column bytes, row 0 in bits [31:24] .. row 3 in bits [7:0]
//   col_out : mixed column, same byte order
module aes_mixcol_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  logic [7:0] b0, b1, b2, b3;

  assign b0 = col_in[31:24];
  assign b1 = col_in[23:16];
  assign b2 = col_in[15:8];
  assign b3 = col_in[7:0];

  // 3*b is written as xtime(b)^b
  assign col_out[31:24] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
  assign col_out[23:16] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
  assign col_out[15:8]  = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
  assign col_out[7:0]   = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
endmodule

// File: rtl/aes_round_mix_stage.sv
// aes_round_mix_stage: ShiftRows -> MixColumns (bypassed when in_last) -> AddRoundKey,
// behind a valid/ready handshake with a 2-entry buffer (output reg + skid reg).
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake; in_ready is the registered "skid empty" flag
//   state_in, round_key : 128-bit state from SubBytes and round key
//   in_round, in_last   : round tag (passed through) and final-round flag
//   out_valid/out_ready : output handshake; state_out/out_round hold while stalled
//   err_round           : sticky, a tag above MAX_ROUND was accepted
//   blk_count           : count of output transfers, saturating at 16'hFFFF
// Build option MIXCOL_PIPE_EN: adds a register between MixColumns and AddRoundKey
// (round key captured alongside), giving 2-cycle latency; buffering is unchanged.
module aes_round_mix_stage
  import aes_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int MAX_ROUND = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic [AES_STATE_W-1:0] round_key,
  input  logic [TAG_W-1:0]       in_round,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic [TAG_W-1:0]       out_round,
  output logic                   err_round,
  output logic [15:0]            blk_count
);
  logic [AES_STATE_W-1:0] sr, mc, mix_sel, push_state;
  logic [TAG_W-1:0]       push_round;
  logic                   in_xfer, out_xfer, push;

  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, err_round_q, err_round_d;
  logic [AES_STATE_W-1:0] out_state_q, out_state_d, skid_state_q, skid_state_d;
  logic [TAG_W-1:0]       out_round_q, out_round_d, skid_round_q, skid_round_d;
  logic [15:0]            blk_count_q, blk_count_d;

  // ShiftRows: out byte[r][c] = in byte[r][(c+r) mod 4]
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam int DST = byte_lsb(r, c);
      localparam int SRC = byte_lsb(r, (c + r) % 4);
      assign sr[DST +: AES_BYTE_W] = state_in[SRC +: AES_BYTE_W];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mixcol_column u_col (
      .col_in (sr[AES_STATE_W-1-32*c -: 32]),
      .col_out(mc[AES_STATE_W-1-32*c -: 32])
    );
  end

  assign mix_sel  = in_last ? sr : mc;
  assign in_ready = ~skid_valid_q;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

`ifdef MIXCOL_PIPE_EN
  logic                   pipe_valid_q, pipe_valid_d;
  logic [AES_STATE_W-1:0] pipe_state_q, pipe_state_d, pipe_key_q, pipe_key_d;
  logic [TAG_W-1:0]       pipe_round_q, pipe_round_d;
  assign push_state = pipe_state_q ^ pipe_key_q;
  assign push_round = pipe_round_q;
`else
  assign push_state = mix_sel ^ round_key;
  assign push_round = in_round;
`endif

  always_comb begin
    out_valid_d  = out_valid_q;
    out_state_d  = out_state_q;
    out_round_d  = out_round_q;
    skid_valid_d = skid_valid_q;
    skid_state_d = skid_state_q;
    skid_round_d = skid_round_q;
    err_round_d  = err_round_q | (in_xfer & (in_round > TAG_W'(MAX_ROUND)));
    blk_count_d  = (out_xfer && blk_count_q != 16'hFFFF) ? blk_count_q + 16'd1 : blk_count_q;

    // Drain first: the skid entry (younger) slides into the output reg.
    if (out_xfer) begin
      if (skid_valid_q) begin
        out_state_d  = skid_state_q;
        out_round_d  = skid_round_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

`ifdef MIXCOL_PIPE_EN
    pipe_valid_d = pipe_valid_q;
    pipe_state_d = pipe_state_q;
    pipe_key_d   = pipe_key_q;
    pipe_round_d = pipe_round_q;
    // The pipe reg advances whenever the buffer has a free slot; with the skid
    // empty (in_ready=1) that always holds, so an accepted input never collides.
    push = pipe_valid_q & (~out_valid_d | ~skid_valid_d);
    if (push) pipe_valid_d = 1'b0;
    if (in_xfer) begin
      pipe_valid_d = 1'b1;
      pipe_state_d = mix_sel;
      pipe_key_d   = round_key;
      pipe_round_d = in_round;
    end
`else
    push = in_xfer;
`endif

    // Fill the output reg when free, else the skid: keeps output older than skid.
    if (push) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_state_d = push_state;
        out_round_d = push_round;
      end else begin
        skid_valid_d = 1'b1;
        skid_state_d = push_state;
        skid_round_d = push_round;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_state_q  <= '0;
      out_round_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_state_q <= '0;
      skid_round_q <= '0;
      err_round_q  <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_state_q  <= out_state_d;
      out_round_q  <= out_round_d;
      skid_valid_q <= skid_valid_d;
      skid_state_q <= skid_state_d;
      skid_round_q <= skid_round_d;
      err_round_q  <= err_round_d;
      blk_count_q  <= blk_count_d;
    end
  end

`ifdef MIXCOL_PIPE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid_q <= 1'b0;
      pipe_state_q <= '0;
      pipe_key_q   <= '0;
      pipe_round_q <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_state_q <= pipe_state_d;
      pipe_key_q   <= pipe_key_d;
      pipe_round_q <= pipe_round_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign state_out = out_state_q;
  assign out_round = out_round_q;
  assign err_round = err_round_q;
  assign blk_count = blk_count_q;
endmodule

// File: tb/tb_aes_round_mix_stage.sv
// Testbench for aes_round_mix_stage: constant vector table, hand-written handshake
// sequences (stall, sticky error, async reset, counter saturation) and a randomized
// phase, all scored against a byte-array AES round model with an ordered queue.
module tb_aes_round_mix_stage;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid, in_ready, in_last, out_valid, out_ready, err_round;
  logic [127:0] state_in, round_key, state_out;
  logic [3:0]   in_round, out_round;
  logic [15:0]  blk_count;

  always #5 clk = ~clk;

  aes_round_mix_stage #(.TAG_W(4), .MAX_ROUND(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .round_key(round_key), .in_round(in_round), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out),
    .out_round(out_round), .err_round(err_round), .blk_count(blk_count)
  );

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic         last;
    logic [3:0]   rnd;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   rnd;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[6];
  int   checks = 0;
  int   errors = 0;
  int   nout = 0;
  int   blk_m = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1B;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                             input logic last);
    logic [7:0] s[4][4];
    logic [7:0] t[4][4];
    logic [7:0] u[4][4];
    logic [7:0] m[4][4];
    logic [127:0] o;
    m = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
          '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = st[127-8*r-32*c -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = s[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        u[r][c] = 8'h00;
        for (int k = 0; k < 4; k++) u[r][c] = u[r][c] ^ gmul(m[r][k], t[k][c]);
        if (last) u[r][c] = t[r][c];
      end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127-8*r-32*c -: 8] = u[r][c];
    return o ^ key;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no DUT response within cycle budget", name);
  endtask

  // One clock: score the output against the queue front, account the
  // handshakes that happen at the coming edge, then advance.
  task automatic cycle();
    bit ix, ox;
    int occ;
    exp_t e;
    occ = exp_q.size();
    ix  = in_valid && in_ready;
    ox  = out_valid && out_ready;
`ifndef MIXCOL_PIPE_EN
    chk("out_valid_occ", out_valid, occ > 0);
    chk("in_ready_occ", in_ready, occ < 2);
`endif
    if (out_valid) begin
      if (occ == 0) timeout_fail("spurious_output");
      else begin
        chk("state_out", state_out, exp_q[0].st);
        chk("out_round", out_round, exp_q[0].rnd);
      end
    end
    if (ox) begin
      if (occ > 0) void'(exp_q.pop_front());
      nout++;
      if (blk_m < 65535) blk_m++;
    end
    if (ix) begin
      e.st  = ref_round(state_in, round_key, in_last);
      e.rnd = in_round;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_input();
    state_in  = {$urandom, $urandom, $urandom, $urandom};
    round_key = {$urandom, $urandom, $urandom, $urandom};
    in_last   = $urandom_range(0, 1) == 1;
    in_round  = 4'($urandom_range(0, 10));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    if (exp_q.size() > 0) timeout_fail(name);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nbase;
    logic [127:0] exp_a;
    bit ix;

    tbl[0] = '{st: 128'hd42711ae_e0bf98f1_b8b45de5_1e415230,
               key: 128'ha0fafe17_88542cb1_23a33939_2a6c7605, last: 1'b0, rnd: 4'd1,
               exp: 128'ha49c7ff2_689f352b_6b5bea43_026a5049};
    tbl[1] = '{st: {4{32'hdb135345}}, key: '0, last: 1'b0, rnd: 4'd2,
               exp: {4{32'h8e4da1bc}}};
    tbl[2] = '{st: {4{32'hf20a225c}}, key: '0, last: 1'b0, rnd: 4'd3,
               exp: {4{32'h9fdc589d}}};
    tbl[3] = '{st: 128'h00112233_44556677_8899aabb_ccddeeff, key: '0, last: 1'b1,
               rnd: 4'd10, exp: 128'h0055aaff_4499ee33_88dd2277_cc1166bb};
    tbl[4] = '{st: 128'h00112233_44556677_8899aabb_ccddeeff, key: {4{32'hffffffff}},
               last: 1'b1, rnd: 4'd0, exp: 128'hffaa5500_bb6611cc_7722dd88_33ee9944};
    tbl[5] = '{st: '0, key: 128'h01234567_89abcdef_fedcba98_76543210, last: 1'b0,
               rnd: 4'd7, exp: 128'h01234567_89abcdef_fedcba98_76543210};

    in_valid = 1'b0; out_ready = 1'b0; state_in = '0; round_key = '0;
    in_round = '0; in_last = 1'b0;

    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state_out", state_out, 0);
    chk("rst_out_round", out_round, 0);
    chk("rst_err_round", err_round, 0);
    chk("rst_blk_count", blk_count, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Known-answer vectors
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      state_in = tbl[i].st; round_key = tbl[i].key;
      in_last = tbl[i].last; in_round = tbl[i].rnd;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
        cycle();
        n++;
      end
      if (!out_valid) timeout_fail("tbl_latency");
      else begin
        chk($sformatf("tbl%0d_state", i), state_out, tbl[i].exp);
        chk($sformatf("tbl%0d_round", i), out_round, tbl[i].rnd);
      end
      cycle();
    end
    drain("tbl_drain");
    chk("err_after_tag10", err_round, 0);

    // Stall: three back-to-back inputs against a blocked output
    nbase = nout;
    out_ready = 1'b0;
    rand_input(); in_valid = 1'b1;
    exp_a = ref_round(state_in, round_key, in_last);
    cycle();
    rand_input();
    cycle();
`ifndef MIXCOL_PIPE_EN
    chk("stall_in_ready_low", in_ready, 0);
`endif
    rand_input();
    cycle();
    chk("stall_hold_state", state_out, exp_a);
    out_ready = 1'b1;
    n = 0;
    while (in_valid && n < 20) begin
      ix = in_valid && in_ready;
      cycle();
      if (ix) in_valid = 1'b0;
      n++;
    end
    if (in_valid) timeout_fail("stall_third_accept");
    drain("stall_drain");
    chk("stall_out_count", nout - nbase, 3);

    // Sticky round-tag error
    rand_input(); in_round = 4'd11; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("err_set", err_round, 1);
    rand_input(); in_round = 4'd3; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    drain("err_drain");
    chk("err_sticky", err_round, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rand_input();
      cycle();
    end
    drain("rand_drain");
    chk("blk_count_rand", blk_count, blk_m);

    // Asynchronous reset with the skid full
    out_ready = 1'b0;
    rand_input(); in_valid = 1'b1;
    cycle();
    rand_input();
    cycle();
    #3 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_state_out", state_out, 0);
    chk("arst_err_round", err_round, 0);
    chk("arst_blk_count", blk_count, 0);
    exp_q.delete();
    blk_m = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Saturating block counter: 65536 output transfers
    nbase = nout;
    out_ready = 1'b1;
    n = 0;
    while ((nout - nbase) < 65536 && n < 70000) begin
      rand_input(); in_valid = 1'b1;
      cycle();
      n++;
    end
    if ((nout - nbase) < 65536) timeout_fail("sat_transfers");
    drain("sat_drain");
    chk("blk_count_sat", blk_count, 16'hFFFF);
    chk("blk_count_model", blk_count, blk_m);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
